// File: rtl/gb_apu_pkg.sv
// Shared APU frame-sequencer types: step index, strobe bundle and step->strobe decode.
package gb_apu_pkg;

   typedef logic [2:0] frame_step_t;

   localparam frame_step_t STEP_SWEEP_A = 3'd2;
   localparam frame_step_t STEP_SWEEP_B = 3'd6;
   localparam frame_step_t STEP_ENV     = 3'd7;

   typedef struct packed {
      logic len;
      logic sweep;
      logic env;
   } fs_strobes_t;

   // Length runs on every even step; sweep on 2 and 6; envelope on 7.
   function automatic fs_strobes_t fs_decode(input frame_step_t s);
      fs_strobes_t r;
      r.len   = ~s[0];
      r.sweep = (s == STEP_SWEEP_A) || (s == STEP_SWEEP_B);
      r.env   = (s == STEP_ENV);
      return r;
   endfunction

endpackage

// File: rtl/gb_div_edge_detect.sv
// Sequencer tick source: falling edge of the selected DIV bit, or an internal
// prescaler when FRAME_SEQ_INTERNAL_DIV_EN is defined.
module gb_div_edge_detect
`ifdef FRAME_SEQ_INTERNAL_DIV_EN
#(
   parameter int unsigned CLK_DIV = 8192,
   parameter int unsigned CNT_W   = $clog2(CLK_DIV)
)
`endif
(
   input  logic       clk,
   input  logic       reset,
   input  logic       apu_en,
   input  logic       double_speed,
   input  logic [7:0] div_reg,
   output logic       tick
);

`ifdef FRAME_SEQ_INTERNAL_DIV_EN
   logic [CNT_W-1:0] cnt_q;
   logic             cnt_wrap;
   logic             unused_div;

   assign unused_div = ^{double_speed, div_reg};
   assign cnt_wrap   = (cnt_q == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || !apu_en) begin
         cnt_q <= '0;
      end else if (cnt_wrap) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = cnt_wrap & apu_en;
`else
   logic sel_bit;
   logic div_prev;
   logic unused_div_bits;

   assign unused_div_bits = ^{div_reg[7:6], div_reg[3:0]};
   assign sel_bit         = double_speed ? div_reg[5] : div_reg[4];

   // Tracks the bit even while powered down so enabling the APU never fakes an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_prev <= 1'b0;
      end else begin
         div_prev <= sel_bit;
      end
   end

   assign tick = div_prev & ~sel_bit & apu_en;
`endif

endmodule

// File: rtl/gb_frame_sequencer.sv
// 512 Hz APU frame sequencer: 8-step counter emitting length/sweep/envelope strobes.
// Optional FRAME_SEQ_INTERNAL_DIV_EN replaces the DIV edge with an internal prescaler.
module gb_frame_sequencer
   import gb_apu_pkg::*;
`ifdef FRAME_SEQ_INTERNAL_DIV_EN
#(
   parameter int unsigned CLK_DIV = 8192,
   parameter int unsigned CNT_W   = $clog2(CLK_DIV)
)
`endif
(
   input  logic       clk,
   input  logic       reset,
   input  logic       apu_en,
   input  logic       double_speed,
   input  logic [7:0] div_reg,
   output logic       clk_length_ctr,
   output logic       clk_sweep,
   output logic       clk_vol_env,
   output logic [2:0] step,
   output logic       next_len_clocked
);

   logic        tick;
   frame_step_t step_q, step_d;
   fs_strobes_t strobes_q, strobes_d;

   gb_div_edge_detect
`ifdef FRAME_SEQ_INTERNAL_DIV_EN
   #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W)
   )
`endif
   u_edge (
      .clk          (clk),
      .reset        (reset),
      .apu_en       (apu_en),
      .double_speed (double_speed),
      .div_reg      (div_reg),
      .tick         (tick)
   );

   // Power-down overrides a coincident tick.
   always_comb begin
      step_d    = step_q;
      strobes_d = '0;
      if (!apu_en) begin
         step_d = '0;
      end else if (tick) begin
         strobes_d = fs_decode(step_q);
         step_d    = step_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         step_q    <= '0;
         strobes_q <= '0;
      end else begin
         step_q    <= step_d;
         strobes_q <= strobes_d;
      end
   end

   assign clk_length_ctr   = strobes_q.len;
   assign clk_sweep        = strobes_q.sweep;
   assign clk_vol_env      = strobes_q.env;
   assign step             = step_q;
   assign next_len_clocked = ~step_q[0];

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Directed bench for gb_frame_sequencer (DIV-edge build).
module tb_gb_frame_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       apu_en;
   logic       double_speed;
   logic [7:0] div_reg;
   logic       clk_length_ctr;
   logic       clk_sweep;
   logic       clk_vol_env;
   logic [2:0] step;
   logic       next_len_clocked;
   logic [2:0] stb;

   int checks = 0;
   int errors = 0;

   logic [2:0] exp_stb [8];

   assign stb = {clk_length_ctr, clk_sweep, clk_vol_env};

   gb_frame_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .apu_en           (apu_en),
      .double_speed     (double_speed),
      .div_reg          (div_reg),
      .clk_length_ctr   (clk_length_ctr),
      .clk_sweep        (clk_sweep),
      .clk_vol_env      (clk_vol_env),
      .step             (step),
      .next_len_clocked (next_len_clocked)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      exp_stb = '{3'b100, 3'b000, 3'b110, 3'b000, 3'b100, 3'b000, 3'b110, 3'b001};

      reset        = 1'b1;
      apu_en       = 1'b1;
      double_speed = 1'b0;
      div_reg      = 8'h00;
      cyc();
      cyc();
      check("reset_stb",  8'(stb), 8'h00);
      check("reset_step", 8'(step), 8'h00);
      check("reset_nlc",  8'(next_len_clocked), 8'h01);
      reset = 1'b0;
      cyc();

      // Eight falling edges of bit 4 walk the whole step map and wrap to 0.
      for (int i = 0; i < 8; i++) begin
         div_reg = 8'h10;
         cyc();
         check("pre_tick_stb", 8'(stb), 8'h00);
         div_reg = 8'h00;
         cyc();
         check("tick_stb",  8'(stb), 8'(exp_stb[i]));
         check("tick_step", 8'(step), 8'((i + 1) % 8));
         check("tick_nlc",  8'(next_len_clocked), 8'((i % 2 == 1) ? 1 : 0));
         cyc();
         check("stb_clear", 8'(stb), 8'h00);
      end

      // Rising edge and steady high: nothing happens.
      div_reg = 8'h10;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("rise_stb",  8'(stb), 8'h00);
         check("rise_step", 8'(step), 8'h00);
      end

      // Double speed: bit 4 chatter is ignored, one bit 5 fall ticks.
      div_reg = 8'h30;
      cyc();
      double_speed = 1'b1;
      cyc();
      check("ds_switch_stb", 8'(stb), 8'h00);
      for (int i = 0; i < 6; i++) begin
         div_reg = (i % 2 == 0) ? 8'h20 : 8'h30;
         cyc();
         check("ds_b4_stb", 8'(stb), 8'h00);
      end
      check("ds_b4_step", 8'(step), 8'h00);
      div_reg = 8'h00;
      cyc();
      check("ds_b5_stb",  8'(stb), 8'h04);
      check("ds_b5_step", 8'(step), 8'h01);
      cyc();
      check("ds_b5_clear", 8'(stb), 8'h00);
      check("ds_b5_hold",  8'(step), 8'h01);

      // Advance to step 5.
      for (int i = 0; i < 4; i++) begin
         div_reg = 8'h20;
         cyc();
         div_reg = 8'h00;
         cyc();
      end
      check("adv_step", 8'(step), 8'h05);

      // Power-down coincident with an edge wins.
      div_reg = 8'h20;
      cyc();
      div_reg = 8'h00;
      apu_en  = 1'b0;
      cyc();
      check("off_stb",  8'(stb), 8'h00);
      check("off_step", 8'(step), 8'h00);
      cyc();
      apu_en = 1'b1;
      cyc();
      check("on_no_spurious", 8'(stb), 8'h00);
      div_reg = 8'h20;
      cyc();
      div_reg = 8'h00;
      cyc();
      check("on_first_stb",  8'(stb), 8'h04);
      check("on_first_step", 8'(step), 8'h01);

      // DIV write-reset while bit 4 is high counts as an edge.
      apu_en       = 1'b0;
      double_speed = 1'b0;
      div_reg      = 8'h10;
      cyc();
      apu_en = 1'b1;
      cyc();
      check("wr_pre_step", 8'(step), 8'h00);
      check("wr_pre_nlc",  8'(next_len_clocked), 8'h01);
      div_reg = 8'h00;
      cyc();
      check("wr_stb",  8'(stb), 8'h04);
      check("wr_step", 8'(step), 8'h01);
      check("wr_nlc",  8'(next_len_clocked), 8'h00);
      cyc();
      check("wr_clear", 8'(stb), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
